// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for data-memory accesses: funct3 size codes, responder
// states and width constants. Also used by the core's MEM stage.
package data_mem_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Number of bytes touched by an access; 0 for the unused size code 11.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    logic [2:0] n;
    n = 3'd0;
    case (funct3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      2'b10:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend.sv
// Load result formatting: picks the B/H/W lanes from the little-endian
// assembled word and applies sign or zero extension; flags illegal funct3.
module load_extend
  import data_mem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              illegal_o
);

  always_comb begin
    rdata_o   = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_H:    rdata_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_W:    rdata_o = word_i;
      F3_BU:   rdata_o = {24'd0, word_i[7:0]};
      F3_HU:   rdata_o = {16'd0, word_i[15:0]};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory behind a valid/ready handshake,
// one access at a time with LATENCY cycles in ACCESS.
// Optional: define DATA_MEM_MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [7:0]          mem_q [DEPTH];
  logic [ADDR_W-1:0]   lane_addr [4];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   ld_rdata;
  logic                ld_illegal;
  logic                store_ok;
  logic                misaligned;
  logic                acc_err;
  logic [DATA_W-1:0]   acc_rdata;
  logic [2:0]          nbytes;
  logic                do_access;
  logic                mem_we;

  // Lane addresses wrap naturally at ADDR_W bits.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_addr[g]       = addr_q + ADDR_W'(g);
    assign rd_word[8*g +: 8]  = mem_q[lane_addr[g]];
  end

  load_extend u_load_extend (
    .word_i    (rd_word),
    .funct3_i  (f3_q),
    .rdata_o   (ld_rdata),
    .illegal_o (ld_illegal)
  );

  assign nbytes   = access_bytes(f3_q);
  assign store_ok = (f3_q == F3_B) || (f3_q == F3_H) || (f3_q == F3_W);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misaligned = (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0]) ||
                      ((f3_q == F3_W) && (addr_q[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign acc_err   = we_q ? (!store_ok || misaligned) : (ld_illegal || misaligned);
  assign acc_rdata = (we_q || acc_err) ? '0 : ld_rdata;
  assign mem_we    = do_access && we_q && !acc_err && !rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid && req_ready) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          rdata_d   = acc_rdata;
          err_d     = acc_err;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; the write lands on the ACCESS-exit edge only.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[lane_addr[0]] <= wdata_q[7:0];
      if (nbytes >= 3'd2) mem_q[lane_addr[1]] <= wdata_q[15:8];
      if (nbytes == 3'd4) begin
        mem_q[lane_addr[2]] <= wdata_q[23:16];
        mem_q[lane_addr[3]] <= wdata_q[31:24];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, reset and
// backpressure sequences, then random traffic against a byte-array model.
module tb_data_mem_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rm [256];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Reference: applies the access rules directly to a byte array.
  function automatic void ref_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    logic legal, mis;
    longint unsigned v;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if (legal && (int'(a) % n) != 0) mis = 1'b1;
`endif
    rd = 32'd0;
    er = 1'b0;
    if (!legal || mis) begin
      er = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) rm[(int'(a) + i) % 256] = 8'(wd >> (8 * i));
      return;
    end
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(rm[(int'(a) + i) % 256]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    rd = v[31:0];
  endfunction

  task automatic xact(input string nm, input logic we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int n;
    int lat;
    rd = 'x;
    er = 'x;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      timeout_fail({nm, "_req_ready"});
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    if (!rsp_valid) begin
      timeout_fail({nm, "_rsp_valid"});
      return;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LAT + 1));
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_hold_rdata"}, rsp_rdata, rd);
      chk({nm, "_hold_err"}, {31'd0, rsp_err}, {31'd0, er});
      chk({nm, "_hold_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({nm, "_idle_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_idle_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_LW_FE  = 32'h0;
  localparam logic        ERR_MIS    = 1'b1;
  localparam logic [31:0] EXP_LBU_FE = 32'h11;
  localparam logic [31:0] EXP_LBU_01 = 32'h44;
`else
  localparam logic [31:0] EXP_LW_FE  = 32'h44332211;
  localparam logic        ERR_MIS    = 1'b0;
  localparam logic [31:0] EXP_LBU_FE = 32'h0D;
  localparam logic [31:0] EXP_LBU_01 = 32'hCA;
`endif

  initial begin
    vec_t tbl[$];
    logic [31:0] rd, erd;
    logic er, eer;

    tbl.push_back('{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 8'h11, 32'h000000A5, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADA5EF, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 8'h11, 32'h0,        32'hFFFFFFA5, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 8'h11, 32'h0,        32'h000000A5, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 8'h20, 32'h00008001, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b001, 8'h20, 32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 8'h20, 32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 8'h10, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 3'b100, 8'h10, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADA5EF, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 8'hFE, 32'h00000011, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'b000, 8'hFF, 32'h00000022, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'b000, 8'h00, 32'h00000033, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 3'b000, 8'h01, 32'h00000044, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b010, 8'hFE, 32'h0,        EXP_LW_FE,    ERR_MIS});
    tbl.push_back('{1'b1, 3'b010, 8'hFE, 32'hCAFEF00D, 32'h0,        ERR_MIS});
    tbl.push_back('{1'b0, 3'b100, 8'hFE, 32'h0,        EXP_LBU_FE,   1'b0});
    tbl.push_back('{1'b0, 3'b100, 8'h01, 32'h0,        EXP_LBU_01,   1'b0});
    tbl.push_back('{1'b1, 3'b010, 8'h30, 32'h12345678, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 3'b010, 8'h30, 32'h0,        32'h12345678, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i]) begin
      xact($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
    end

    // Consumer backpressure for 5 cycles
    xact("hold", 1'b0, 3'b010, 8'h10, 32'h0, 5, rd, er);
    chk("hold_rdata", rd, 32'hDEADA5EF);

    // Reset while a store is still in ACCESS: store must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 8'h30; req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_release_req_ready", {31'd0, req_ready}, 32'd1);
    xact("midrst_lw", 1'b0, 3'b010, 8'h30, 32'h0, 0, rd, er);
    chk("midrst_lw_rdata", rd, 32'h12345678);
    chk("midrst_lw_err", {31'd0, er}, 32'd0);

    // Random traffic: fill every word first so the model knows all bytes
    for (int k = 0; k < 64; k++) begin
      logic [31:0] w;
      w = $urandom;
      ref_op(1'b1, 3'b010, 8'(4 * k), w, erd, eer);
      xact("init", 1'b1, 3'b010, 8'(4 * k), w, 0, rd, er);
    end
    for (int k = 0; k < 150; k++) begin
      logic we;
      logic [2:0] f3;
      logic [7:0] a;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 8'($urandom_range(0, 255));
      wd = $urandom;
      ref_op(we, f3, a, wd, erd, eer);
      xact($sformatf("rnd%0d", k), we, f3, a, wd, $urandom_range(0, 2), rd, er);
      chk($sformatf("rnd%0d_rdata", k), rd, erd);
      chk($sformatf("rnd%0d_err", k), {31'd0, er}, {31'd0, eer});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory accesses (loads/stores with funct3 size codes) over a valid/ready request/response handshake.
- Holds a byte-addressed, little-endian store and services one access at a time with configurable latency.
- Performs write byte-lane masking, load lane extraction and sign/zero extension.
- Sits between the core's MEM stage (or a bus adapter) and the backing storage.

Parameters:
- ADDR_W, 8, byte-address width; memory holds 2**ADDR_W bytes.
- LATENCY, 2, cycles spent in ACCESS before the response is offered; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result (extended); 0 for stores
- rsp_err  out  1  illegal funct3 (or misaligned, see optional feature)

Behaviour:
- Reset values: req_ready=0 while rst is high, 1 in the first cycle after rst deasserts; rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE; latency counter=0. Memory contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready, capture we/funct3/addr/wdata, load counter=LATENCY-1, go to ACCESS.
  - ACCESS: req_ready=0. Decrement the counter each cycle. When counter==0, perform the access and go to RESP in the next cycle.
  - RESP: rsp_valid=1, with rdata/err held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
  - rsp_ready high in the same cycle RESP is entered completes the handshake in one cycle.
- Latency: request-accept edge to first rsp_valid cycle is LATENCY+1 cycles. Back-to-back requests are accepted no faster than every LATENCY+2 cycles.
- Store: write bytes addr..addr+n-1, with n=1/2/4 for B/H/W, from wdata[8n-1:0]. Bytes outside that lane set are unchanged. Store with funct3 BU/HU/011/11x gives err=1 and no write.
- Load: assemble n bytes little-endian. B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through. Illegal funct3 gives rdata=0, err=1.
- Address arithmetic wraps modulo 2**ADDR_W (e.g. a W load at 0xFE reads bytes FE,FF,00,01) unless the optional feature traps first.
- Memory is written exactly once per accepted store, on the ACCESS-exit edge.
- A store followed by a load to the same address returns the new data.
- Reset mid-operation: the state returns to IDLE and the pending response is discarded. A store whose write edge has not yet occurred is dropped.
- No outstanding-request queue; req_ready=0 outside IDLE is the only backpressure.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]!=0, or W with addr[1:0]!=0, responds err=1, rdata=0, and performs no write.
- Undefined: misaligned accesses are serviced byte-wise with wrap-around as above, err=0.

Decomposition:
- Shared package: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE/ACCESS/RESP), width constants. The core's MEM stage reuses the same package.
- One sub-module, load_extend: combinational, takes 32-bit assembled bytes and funct3, returns extended rdata and an illegal flag.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, err=0; first rsp_valid exactly LATENCY+1 cycles after accept.
- SB 0x11 wdata 0x000000A5 over the previous word, then LW 0x10 -> 0xDEADA5EF; LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
- SH 0x20 wdata 0x00008001, then LH 0x20 -> 0xFFFF8001; LHU 0x20 -> 0x00008001.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; release -> returns to IDLE next cycle.
- LW 0xFE, with bytes FE..01 preloaded 11,22,33,44 -> without the macro rdata=0x44332211, err=0; with DATA_MEM_MISALIGN_TRAP_EN rdata=0, err=1, and a subsequent SW 0xFE leaves memory unchanged.
- Funct3=011 load -> err=1, rdata=0. Assert rst during ACCESS of a SW to 0x30 -> LW 0x30 afterwards returns the old value and rsp_valid=0 immediately on reset.
